jesd204b_rx_tpl: RTL and testbench

Receive-side JESD204B transport layer. Accepts octet-aligned per-lane streams from the RX data link layer, one octet per lane per clock, and collects F octets per lane into a frame. Each completed frame is demapped into converter samples and, optionally, control bits. It is the exact inverse of the team's TX transport mapping and sits between the RX link layer (after ILAS/frame alignment) and the ADC sample consumers.

---
 rtl/jesd204b_pkg.sv | 30 +++
 rtl/jesd204b_rx_lane_buf.sv | 34 +++
 rtl/jesd204b_rx_tpl.sv | 163 ++++++++++++++++
 tb/tb_jesd204b_rx_tpl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204b_pkg.sv
// Shared JESD204B transport-layer definitions: derived frame geometry,
// the RX framing FSM state type and lane/octet index helpers (also used by TX).
package jesd204b_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        RUN  = 1'b1
    } tpl_state_t;

    // F: octets per lane per frame
    function automatic int calc_octets_per_frame(input int m, input int s,
                                                 input int np, input int l);
        return (m * s * np) / (8 * l);
    endfunction

    function automatic int calc_tails(input int np, input int n, input int cs);
        return np - n - cs;
    endfunction

    // Converter carried by octet pair 'pair' of lane 'lane'
    function automatic int conv_index(input int lane, input int pair, input int f);
        return lane * (f / 2) + pair;
    endfunction

    // Bit offset of octet 'octet' of lane 'lane' in a lane-major flattened frame
    function automatic int octet_bit(input int lane, input int octet, input int f);
        return (lane * f + octet) * 8;
    endfunction

endpackage

// File: rtl/jesd204b_rx_lane_buf.sv
// Per-lane capture buffer: holds octets 0..F-2 of the frame in progress;
// the final octet is taken straight from the lane input at frame completion.
module jesd204b_rx_lane_buf
    import jesd204b_pkg::*;
#(
    parameter int F     = 4,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_idx,
    input  logic [7:0]         octet,
    output logic [(F-1)*8-1:0] slots
);

    genvar gi;
    generate
        for (gi = 0; gi < F - 1; gi++) begin : g_slot
            logic [7:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
                    slot_reg <= octet;
                end
            end

            assign slots[octet_bit(0, gi, F) +: 8] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/jesd204b_rx_tpl.sv
// JESD204B receive transport layer: frames per-lane octet streams and demaps
// each frame into converter samples. Define JESD204B_RX_CTRL_EN to also output control bits.
module jesd204b_rx_tpl
    import jesd204b_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int CONVERTERS  = 8,
    parameter int RESOLUTION  = 11,
    parameter int CONTROL     = 2,
    parameter int SAMPLE_SIZE = 16,
    parameter int SAMPLES     = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [8*LANES-1:0]                       rx_datain,
    input  logic                                     rx_valid,
    input  logic                                     rx_sof,
    output logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] rx_dataout,
`ifdef JESD204B_RX_CTRL_EN
    output logic [SAMPLES*CONVERTERS*CONTROL-1:0]    rx_ctrl,
`endif
    output logic                                     rx_dout_valid,
    output logic                                     rx_aligned,
    output logic                                     frame_err
);

    localparam int F     = calc_octets_per_frame(CONVERTERS, SAMPLES, SAMPLE_SIZE, LANES);
    localparam int CNT_W = (F > 1) ? $clog2(F) : 1;
    localparam logic [CNT_W-1:0] LAST_OCT = CNT_W'(F - 1);

    tpl_state_t state_reg, state_next;
    logic [CNT_W-1:0] oct_cnt_reg, oct_cnt_next;
    logic aligned_reg, aligned_next;
    logic err_reg, err_next;
    logic dv_reg, complete;
    logic wr_en;
    logic [CNT_W-1:0] wr_idx;

    logic [LANES-1:0][(F-1)*8-1:0] lane_slots;
    logic [LANES*F*8-1:0] frame_bits;
    logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] samples_demap, dataout_reg;

    always_comb begin
        state_next   = state_reg;
        oct_cnt_next = oct_cnt_reg;
        aligned_next = aligned_reg;
        err_next     = 1'b0;
        complete     = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = oct_cnt_reg;
        case (state_reg)
            SEEK: begin
                if (rx_valid && rx_sof) begin
                    state_next   = RUN;
                    aligned_next = 1'b1;
                    wr_en        = 1'b1;
                    wr_idx       = '0;
                    oct_cnt_next = CNT_W'(1);
                end
            end
            RUN: begin
                if (rx_valid) begin
                    // A start-of-frame inside a frame restarts framing at this octet
                    if (rx_sof && (oct_cnt_reg != '0)) begin
                        err_next     = 1'b1;
                        wr_en        = 1'b1;
                        wr_idx       = '0;
                        oct_cnt_next = CNT_W'(1);
                    end else if (oct_cnt_reg == LAST_OCT) begin
                        complete     = 1'b1;
                        oct_cnt_next = '0;
                    end else begin
                        wr_en        = 1'b1;
                        oct_cnt_next = oct_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= SEEK;
            oct_cnt_reg <= '0;
            aligned_reg <= 1'b0;
            err_reg     <= 1'b0;
            dv_reg      <= 1'b0;
            dataout_reg <= '0;
        end else begin
            state_reg   <= state_next;
            oct_cnt_reg <= oct_cnt_next;
            aligned_reg <= aligned_next;
            err_reg     <= err_next;
            dv_reg      <= complete;
            if (complete) begin
                dataout_reg <= samples_demap;
            end
        end
    end

    genvar gi, gp;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            jesd204b_rx_lane_buf #(
                .F     (F),
                .CNT_W (CNT_W)
            ) u_lane_buf (
                .clk    (clk),
                .rst_n  (rst_n),
                .wr_en  (wr_en),
                .wr_idx (wr_idx),
                .octet  (rx_datain[gi*8 +: 8]),
                .slots  (lane_slots[gi])
            );

            // Last octet bypasses the buffer so the frame decodes on its own edge
            assign frame_bits[octet_bit(gi, 0, F) +: (F-1)*8] = lane_slots[gi];
            assign frame_bits[octet_bit(gi, F-1, F) +: 8]     = rx_datain[gi*8 +: 8];
        end
    endgenerate

`ifdef JESD204B_RX_CTRL_EN
    logic [SAMPLES*CONVERTERS*CONTROL-1:0] ctrl_demap, ctrl_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
        end else if (complete) begin
            ctrl_reg <= ctrl_demap;
        end
    end

    assign rx_ctrl = ctrl_reg;
`endif

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_demap_lane
            for (gp = 0; gp < F / 2; gp++) begin : g_pair
                localparam int K = conv_index(gi, gp, F);
                logic [SAMPLE_SIZE-1:0] w;
                logic unused_w;

                assign w = {frame_bits[octet_bit(gi, 2*gp, F) +: 8],
                            frame_bits[octet_bit(gi, 2*gp+1, F) +: 8]};
                assign samples_demap[K*RESOLUTION +: RESOLUTION] =
                    w[SAMPLE_SIZE-1 -: RESOLUTION];
`ifdef JESD204B_RX_CTRL_EN
                assign ctrl_demap[K*CONTROL +: CONTROL] =
                    w[SAMPLE_SIZE-1-RESOLUTION -: CONTROL];
`endif
                // Tail bits (and control bits when not exported) are dropped
                assign unused_w = ^w;
            end
        end
    endgenerate

    assign rx_dataout    = dataout_reg;
    assign rx_dout_valid = dv_reg;
    assign rx_aligned    = aligned_reg;
    assign frame_err     = err_reg;

endmodule

// File: tb/tb_jesd204b_rx_tpl.sv
// Self-checking bench for jesd204b_rx_tpl: random frames built by a TX-side
// mapper model, checked cycle by cycle against expected pulses and samples.
module tb_jesd204b_rx_tpl;

    localparam int L     = 4;
    localparam int M     = 8;
    localparam int N     = 11;
    localparam int CS    = 2;
    localparam int F     = 4;
    localparam int TAILS = 16 - N - CS;

    logic clk = 1'b0;
    logic rst_n;
    logic [8*L-1:0] rx_datain;
    logic rx_valid;
    logic rx_sof;
    logic [M*N-1:0] rx_dataout;
`ifdef JESD204B_RX_CTRL_EN
    logic [M*CS-1:0] rx_ctrl;
`endif
    logic rx_dout_valid;
    logic rx_aligned;
    logic frame_err;

    int total = 0;
    int bad   = 0;

    logic [M*N-1:0]  last_smp;
    logic [M*CS-1:0] last_ctl;

    jesd204b_rx_tpl #(
        .LANES       (L),
        .CONVERTERS  (M),
        .RESOLUTION  (N),
        .CONTROL     (CS),
        .SAMPLE_SIZE (16),
        .SAMPLES     (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_datain     (rx_datain),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .rx_dataout    (rx_dataout),
`ifdef JESD204B_RX_CTRL_EN
        .rx_ctrl       (rx_ctrl),
`endif
        .rx_dout_valid (rx_dout_valid),
        .rx_aligned    (rx_aligned),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [8*L-1:0] d, input logic v, input logic s);
        rx_datain = d;
        rx_valid  = v;
        rx_sof    = s;
        @(posedge clk);
        #1;
    endtask

    // Octet j of every lane, from a lane-major frame image
    function automatic logic [8*L-1:0] octet_col(input logic [8*L*F-1:0] fb, input int j);
        logic [8*L-1:0] r;
        for (int i = 0; i < L; i++) r[i*8 +: 8] = fb[(i*F + j)*8 +: 8];
        return r;
    endfunction

    // TX-side mapper: random samples/control/tails packed into a frame
    task automatic tx_map(output logic [8*L*F-1:0] fb, output logic [M*N-1:0] smp,
                          output logic [M*CS-1:0] ctl);
        fb = '0;
        for (int k = 0; k < M; k++) begin
            int lane = k / (F / 2);
            int m    = k % (F / 2);
            int s    = int'($urandom_range(0, (1 << N) - 1));
            int c    = int'($urandom_range(0, (1 << CS) - 1));
            int t    = int'($urandom_range(0, (1 << TAILS) - 1));
            int w    = s * (1 << (16 - N)) + c * (1 << TAILS) + t;
            fb[(lane*F + 2*m)*8 +: 8]     = w[15:8];
            fb[(lane*F + 2*m + 1)*8 +: 8] = w[7:0];
            smp[k*N +: N]   = s[N-1:0];
            ctl[k*CS +: CS] = c[CS-1:0];
        end
    endtask

    // Receive-side decode by arithmetic on the 16-bit words
    function automatic logic [M*N-1:0] model_samples(input logic [8*L*F-1:0] fb);
        logic [M*N-1:0] r;
        for (int k = 0; k < M; k++) begin
            int lane = k / (F / 2);
            int m    = k % (F / 2);
            int w    = int'(fb[(lane*F + 2*m)*8 +: 8]) * 256 + int'(fb[(lane*F + 2*m + 1)*8 +: 8]);
            int s    = (w / (1 << (16 - N))) % (1 << N);
            r[k*N +: N] = s[N-1:0];
        end
        return r;
    endfunction

    function automatic logic [M*CS-1:0] model_ctrl(input logic [8*L*F-1:0] fb);
        logic [M*CS-1:0] r;
        for (int k = 0; k < M; k++) begin
            int lane = k / (F / 2);
            int m    = k % (F / 2);
            int w    = int'(fb[(lane*F + 2*m)*8 +: 8]) * 256 + int'(fb[(lane*F + 2*m + 1)*8 +: 8]);
            int c    = (w / (1 << TAILS)) % (1 << CS);
            r[k*CS +: CS] = c[CS-1:0];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'b1, 1'(i == 0));
            total++;
            if ({rx_dout_valid, rx_aligned, frame_err} !== 3'b000) begin
                bad++;
                $display("FAIL reset_flags cyc=%0d got=%b want=000", i,
                         {rx_dout_valid, rx_aligned, frame_err});
            end
            total++;
            if (rx_dataout !== '0) begin
                bad++;
                $display("FAIL reset_data got=%h want=0", rx_dataout);
            end
`ifdef JESD204B_RX_CTRL_EN
            total++;
            if (rx_ctrl !== '0) begin
                bad++;
                $display("FAIL reset_ctrl got=%h want=0", rx_ctrl);
            end
`endif
        end
        rst_n = 1'b1;
        drive('0, 1'b0, 1'b0);
        total++;
        if (rx_aligned !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_aligned got=%b want=0", rx_aligned);
        end
        last_smp = '0;
        last_ctl = '0;
        $display("test_reset: done");
    endtask

    task automatic test_frame_decode();
        logic [8*L*F-1:0] fb;
        logic [M*N-1:0] exp_smp;
        fb = '0;
        fb[0 +: 8] = 8'hB4;
        fb[8 +: 8] = 8'h70;
        exp_smp = '0;
        exp_smp[N-1:0] = 11'h5A3;
        for (int j = 0; j < F; j++) begin
            drive(octet_col(fb, j), 1'b1, 1'(j == 0));
            total++;
            if (rx_dout_valid !== 1'(j == F - 1) || rx_aligned !== 1'b1) begin
                bad++;
                $display("FAIL decode_pulse oct=%0d got dv=%b al=%b want dv=%b al=1",
                         j, rx_dout_valid, rx_aligned, j == F - 1);
            end
        end
        total++;
        if (rx_dataout !== exp_smp) begin
            bad++;
            $display("FAIL decode_data got=%h want=%h", rx_dataout, exp_smp);
        end
`ifdef JESD204B_RX_CTRL_EN
        total++;
        if (rx_ctrl[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL decode_ctrl got=%b want=10", rx_ctrl[1:0]);
        end
        last_ctl = rx_ctrl;
`endif
        drive('0, 1'b0, 1'b0);
        total++;
        if (rx_dout_valid !== 1'b0 || rx_dataout !== exp_smp) begin
            bad++;
            $display("FAIL decode_hold got dv=%b data=%h want dv=0 data=%h",
                     rx_dout_valid, rx_dataout, exp_smp);
        end
        last_smp = exp_smp;
        $display("test_frame_decode: conv0=%h", rx_dataout[N-1:0]);
    endtask

    task automatic test_back_to_back();
        logic [8*L*F-1:0] fb;
        logic [M*N-1:0]   smp;
        logic [M*CS-1:0]  ctl;
        for (int f = 0; f < 3; f++) begin
            tx_map(fb, smp, ctl);
            for (int j = 0; j < F; j++) begin
                drive(octet_col(fb, j), 1'b1, 1'(f == 0 && j == 0));
                total++;
                if (rx_dout_valid !== 1'(j == F - 1)) begin
                    bad++;
                    $display("FAIL b2b_pulse frame=%0d oct=%0d got=%b want=%b",
                             f, j, rx_dout_valid, j == F - 1);
                end
                total++;
                if (j == F - 1) begin
                    if (rx_dataout !== smp) begin
                        bad++;
                        $display("FAIL b2b_data frame=%0d got=%h want=%h", f, rx_dataout, smp);
                    end
                end else if (rx_dataout !== last_smp) begin
                    bad++;
                    $display("FAIL b2b_hold frame=%0d oct=%0d got=%h want=%h",
                             f, j, rx_dataout, last_smp);
                end
`ifdef JESD204B_RX_CTRL_EN
                if (j == F - 1) begin
                    total++;
                    if (rx_ctrl !== ctl) begin
                        bad++;
                        $display("FAIL b2b_ctrl frame=%0d got=%h want=%h", f, rx_ctrl, ctl);
                    end
                end
`endif
            end
            last_smp = smp;
            last_ctl = ctl;
            $display("test_back_to_back: frame %0d conv0=%h", f, smp[N-1:0]);
        end
    endtask

    task automatic test_stall();
        logic [8*L*F-1:0] fb;
        logic [M*N-1:0]   smp;
        logic [M*CS-1:0]  ctl;
        int cyc = 0;
        tx_map(fb, smp, ctl);
        for (int j = 0; j < F; j++) begin
            drive(octet_col(fb, j), 1'b1, 1'(j == 0));
            cyc++;
            if (j == 1) begin
                for (int s = 0; s < 2; s++) begin
                    drive($urandom, 1'b0, 1'($urandom_range(0, 1)));
                    cyc++;
                    total++;
                    if (rx_dout_valid !== 1'b0 || rx_dataout !== last_smp) begin
                        bad++;
                        $display("FAIL stall_hold cyc=%0d got dv=%b data=%h want dv=0 data=%h",
                                 cyc, rx_dout_valid, rx_dataout, last_smp);
                    end
                end
            end else begin
                total++;
                if (rx_dout_valid !== 1'(j == F - 1)) begin
                    bad++;
                    $display("FAIL stall_pulse cyc=%0d got=%b want=%b", cyc, rx_dout_valid, j == F - 1);
                end
            end
        end
        total++;
        if (cyc != F + 2 || rx_dataout !== smp || rx_dataout !== model_samples(fb)) begin
            bad++;
            $display("FAIL stall_data cyc=%0d got=%h want=%h", cyc, rx_dataout, smp);
        end
`ifdef JESD204B_RX_CTRL_EN
        total++;
        if (rx_ctrl !== model_ctrl(fb)) begin
            bad++;
            $display("FAIL stall_ctrl got=%h want=%h", rx_ctrl, model_ctrl(fb));
        end
`endif
        last_smp = smp;
        last_ctl = ctl;
        $display("test_stall: pulse after %0d cycles", cyc);
    endtask

    task automatic test_misalign();
        logic [8*L*F-1:0] fa, fb;
        logic [M*N-1:0]   smp;
        logic [M*CS-1:0]  ctl;
        tx_map(fa, smp, ctl);
        for (int i = 0; i < 8*L*F; i += 32) fb[i +: 32] = $urandom;
        drive(octet_col(fa, 0), 1'b1, 1'b1);
        drive(octet_col(fa, 1), 1'b1, 1'b0);
        for (int j = 0; j < F; j++) begin
            drive(octet_col(fb, j), 1'b1, 1'(j == 0));
            total++;
            if (frame_err !== 1'(j == 0) || rx_dout_valid !== 1'(j == F - 1) || rx_aligned !== 1'b1) begin
                bad++;
                $display("FAIL misalign_flags oct=%0d got err=%b dv=%b al=%b want err=%b dv=%b al=1",
                         j, frame_err, rx_dout_valid, rx_aligned, j == 0, j == F - 1);
            end
        end
        total++;
        if (rx_dataout !== model_samples(fb)) begin
            bad++;
            $display("FAIL misalign_data got=%h want=%h", rx_dataout, model_samples(fb));
        end
`ifdef JESD204B_RX_CTRL_EN
        total++;
        if (rx_ctrl !== model_ctrl(fb)) begin
            bad++;
            $display("FAIL misalign_ctrl got=%h want=%h", rx_ctrl, model_ctrl(fb));
        end
`endif
        last_smp = model_samples(fb);
        last_ctl = model_ctrl(fb);
        $display("test_misalign: realigned conv0=%h", last_smp[N-1:0]);
    endtask

    task automatic test_reset_mid();
        logic [8*L*F-1:0] fa, fb;
        logic [M*N-1:0]   smp;
        logic [M*CS-1:0]  ctl;
        tx_map(fa, smp, ctl);
        drive(octet_col(fa, 0), 1'b1, 1'b1);
        drive(octet_col(fa, 1), 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(octet_col(fa, 2), 1'b1, 1'b0);
        total++;
        if ({rx_dout_valid, rx_aligned, frame_err} !== 3'b000 || rx_dataout !== '0) begin
            bad++;
            $display("FAIL midrst_state got flags=%b data=%h want 000 and 0",
                     {rx_dout_valid, rx_aligned, frame_err}, rx_dataout);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? octet_col(fa, 3) : 32'($urandom), 1'b1, 1'b0);
            total++;
            if (rx_dout_valid !== 1'b0 || rx_aligned !== 1'b0) begin
                bad++;
                $display("FAIL midrst_seek cyc=%0d got dv=%b al=%b want 0 0",
                         i, rx_dout_valid, rx_aligned);
            end
        end
        tx_map(fb, smp, ctl);
        for (int j = 0; j < F; j++) begin
            drive(octet_col(fb, j), 1'b1, 1'(j == 0));
            total++;
            if (rx_dout_valid !== 1'(j == F - 1) || rx_aligned !== 1'b1) begin
                bad++;
                $display("FAIL midrst_reacq oct=%0d got dv=%b al=%b want dv=%b al=1",
                         j, rx_dout_valid, rx_aligned, j == F - 1);
            end
        end
        total++;
        if (rx_dataout !== smp) begin
            bad++;
            $display("FAIL midrst_data got=%h want=%h", rx_dataout, smp);
        end
`ifdef JESD204B_RX_CTRL_EN
        total++;
        if (rx_ctrl !== ctl) begin
            bad++;
            $display("FAIL midrst_ctrl got=%h want=%h", rx_ctrl, ctl);
        end
`endif
        $display("test_reset_mid: reacquired conv0=%h", smp[N-1:0]);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_datain = '0;
        rx_valid  = 1'b0;
        rx_sof    = 1'b0;
        last_smp  = '0;
        last_ctl  = '0;
        test_reset();
        test_frame_decode();
        test_back_to_back();
        test_stall();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
